// File: rtl/ahb2_apb_bridge.sv
// AHB2 slave to APB3 master bridge: each accepted AHB beat becomes one APB
// SETUP/ACCESS transaction, with alignment/size checks and a bounded ACCESS timeout.
module ahb2_apb_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hsel_i,
  input  logic [ADDR_WIDTH-1:0] haddr_i,
  input  logic [1:0]            htrans_i,
  input  logic                  hwrite_i,
  input  logic [2:0]            hsize_i,
  input  logic [2:0]            hburst_i,
  input  logic [DATA_WIDTH-1:0] hwdata_i,
  input  logic                  hready_i,
  output logic                  hreadyout_o,
  output logic [1:0]            hresp_o,
  output logic [DATA_WIDTH-1:0] hrdata_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [DATA_WIDTH-1:0] pwdata_o,
  input  logic [DATA_WIDTH-1:0] prdata_i,
  input  logic                  pready_i,
  input  logic                  pslverr_i
);

  localparam int MAX_SIZE = $clog2(DATA_WIDTH / 8);
  localparam int CNT_W    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam logic TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_DONE,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] paddr_reg;
  logic                  pwrite_reg;
  logic [DATA_WIDTH-1:0] hrdata_reg;
  logic [CNT_W-1:0]      cnt_reg;

  logic       accept_window;
  logic       accept;
  logic       illegal;
  logic [6:0] addr_low;
  logic [6:0] align_mask;
  logic       psel_comb, penable_comb, hreadyout_comb;
  logic [1:0] hresp_comb;

  // Burst type and the NONSEQ/SEQ distinction do not affect behaviour.
  logic unused_inputs;
  assign unused_inputs = ^{hburst_i, htrans_i[0]};

  assign accept_window = (state_reg == ST_IDLE) || (state_reg == ST_DONE) ||
                         (state_reg == ST_ERR2);
  assign accept        = accept_window && hsel_i && hready_i && htrans_i[1];

  // Only the low 7 address bits matter: hsize tops out at 128 bytes.
  assign addr_low   = 7'(haddr_i);
  assign align_mask = (7'd1 << hsize_i) - 7'd1;
  assign illegal    = (hsize_i > 3'(MAX_SIZE)) || (|(addr_low & align_mask));

  always_comb begin
    state_next     = state_reg;
    psel_comb      = 1'b0;
    penable_comb   = 1'b0;
    hreadyout_comb = 1'b1;
    hresp_comb     = RESP_OKAY;
    case (state_reg)
      ST_IDLE, ST_DONE, ST_ERR2: begin
        hresp_comb = (state_reg == ST_ERR2) ? RESP_ERROR : RESP_OKAY;
        if (accept) begin
          state_next = illegal ? ST_ERR1 : ST_SETUP;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_SETUP: begin
        psel_comb      = 1'b1;
        hreadyout_comb = 1'b0;
        state_next     = ST_ACCESS;
      end
      ST_ACCESS: begin
        psel_comb      = 1'b1;
        penable_comb   = 1'b1;
        hreadyout_comb = 1'b0;
        if (pready_i) begin
          state_next = pslverr_i ? ST_ERR1 : ST_DONE;
        end else if (TIMEOUT_EN && (cnt_reg == CNT_LAST)) begin
          state_next = ST_ERR1;
        end
      end
      ST_ERR1: begin
        hreadyout_comb = 1'b0;
        hresp_comb     = RESP_ERROR;
        state_next     = ST_ERR2;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      paddr_reg  <= '0;
      pwrite_reg <= 1'b0;
      hrdata_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        paddr_reg  <= haddr_i;
        pwrite_reg <= hwrite_i;
      end
      if (state_next == ST_SETUP) begin
        cnt_reg <= '0;
      end else if (state_reg == ST_ACCESS) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      if ((state_reg == ST_ACCESS) && pready_i && !pslverr_i && !pwrite_reg) begin
        hrdata_reg <= prdata_i;
      end
    end
  end

  assign hreadyout_o = hreadyout_comb;
  assign hresp_o     = hresp_comb;
  assign hrdata_o    = hrdata_reg;
  assign paddr_o     = paddr_reg;
  assign psel_o      = psel_comb;
  assign penable_o   = penable_comb;
  assign pwrite_o    = pwrite_reg;
  // The AHB master holds hwdata while hreadyout is low, so this is stable for the APB beat.
  assign pwdata_o    = hwdata_i;

endmodule

// File: tb/tb_ahb2_apb_bridge.sv
// Directed bench for ahb2_apb_bridge: a transfer-level model expands each AHB beat
// into its expected per-cycle bus picture, checked by one compare process.
module tb_ahb2_apb_bridge;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 4;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;
  localparam logic [1:0] OKAY     = 2'b00;
  localparam logic [1:0] ERR      = 2'b01;

  logic          clk = 1'b0;
  logic          rst;
  logic          hsel;
  logic [AW-1:0] haddr;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [2:0]    hsize;
  logic [2:0]    hburst;
  logic [DW-1:0] hwdata;
  logic          hready_in;
  logic          hreadyout;
  logic [1:0]    hresp;
  logic [DW-1:0] hrdata;
  logic [AW-1:0] paddr;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;

  always #5 clk = ~clk;

  ahb2_apb_bridge #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .hsel_i     (hsel),
    .haddr_i    (haddr),
    .htrans_i   (htrans),
    .hwrite_i   (hwrite),
    .hsize_i    (hsize),
    .hburst_i   (hburst),
    .hwdata_i   (hwdata),
    .hready_i   (hready_in),
    .hreadyout_o(hreadyout),
    .hresp_o    (hresp),
    .hrdata_o   (hrdata),
    .paddr_o    (paddr),
    .psel_o     (psel),
    .penable_o  (penable),
    .pwrite_o   (pwrite),
    .pwdata_o   (pwdata),
    .prdata_i   (prdata),
    .pready_i   (pready),
    .pslverr_i  (pslverr)
  );

  typedef struct {
    logic          rdy;
    logic [1:0]    resp;
    logic          ps;
    logic          pe;
    logic [AW-1:0] pa;
    logic          pw;
    logic [DW-1:0] pd;
    logic [DW-1:0] rd;
  } exp_t;

  exp_t          exp_q[$];
  int            checks   = 0;
  int            failures = 0;
  logic          pend_err = 1'b0;
  logic [DW-1:0] exp_rdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, req);
    end
  endtask

  // Compare process: one expected bus picture per checked cycle, sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("hreadyout", {31'b0, hreadyout}, {31'b0, e.rdy});
        chk("hresp", {30'b0, hresp}, {30'b0, e.resp});
        chk("psel", {31'b0, psel}, {31'b0, e.ps});
        chk("penable", {31'b0, penable}, {31'b0, e.pe});
        chk("hrdata", hrdata, e.rd);
        if (e.ps) begin
          chk("paddr", paddr, e.pa);
          chk("pwrite", {31'b0, pwrite}, {31'b0, e.pw});
          chk("pwdata", pwdata, e.pd);
        end
      end
    end
  end

  task automatic push(input logic rdy, input logic [1:0] resp, input logic ps, input logic pe,
                      input logic [AW-1:0] pa, input logic pw, input logic [DW-1:0] pd);
    exp_t e;
    e.rdy = rdy; e.resp = resp; e.ps = ps; e.pe = pe;
    e.pa = pa; e.pw = pw; e.pd = pd; e.rd = exp_rdata;
    exp_q.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // A cycle where the bridge is ready: it completes any previous beat (OKAY or ERROR).
  task automatic ready_cycle();
    push(1'b1, pend_err ? ERR : OKAY, 1'b0, 1'b0, '0, 1'b0, '0);
    pend_err = 1'b0;
    next_cycle();
  endtask

  task automatic idle_cycle(input logic sel, input logic [1:0] tr, input logic rdy_in);
    hsel = sel; htrans = tr; hready_in = rdy_in;
    haddr = 32'h0000_0040; hwrite = 1'b1; hsize = 3'd2;
    ready_cycle();
    hready_in = 1'b1;
  endtask

  // One AHB beat; returns at the start of its completion cycle (the next beat's address phase).
  task automatic xfer(input logic [1:0] tr, input logic [AW-1:0] addr, input logic wr,
                      input logic [2:0] size, input logic [DW-1:0] wd, input logic [DW-1:0] rd,
                      input int waits, input logic slverr);
    logic legal;
    logic timeout;
    int   n;
    legal   = (size <= 3'd2) && ((addr % (32'd1 << size)) == 0);
    timeout = legal && !slverr && (waits >= TMO);
    $display("xfer %s addr=%h size=%0d waits=%0d slverr=%0d legal=%0d timeout=%0d",
             wr ? "WR" : "RD", addr, size, waits, slverr, legal, timeout);
    hsel = 1'b1; htrans = tr; haddr = addr; hwrite = wr; hsize = size; hready_in = 1'b1;
    ready_cycle();
    hsel = 1'b0; htrans = T_IDLE; haddr = ~addr; hwrite = ~wr; hwdata = wd;
    if (!legal) begin
      push(1'b0, ERR, 1'b0, 1'b0, '0, 1'b0, '0);
      pend_err = 1'b1;
      next_cycle();
      return;
    end
    push(1'b0, OKAY, 1'b1, 1'b0, addr, wr, wd);
    next_cycle();
    n = timeout ? TMO : waits + 1;
    for (int i = 0; i < n; i++) begin
      pready  = !timeout && (i == n - 1);
      pslverr = pready && slverr;
      prdata  = wr ? 32'hBAD0_BAD0 : (pready ? rd : ~rd);
      push(1'b0, OKAY, 1'b1, 1'b1, addr, wr, wd);
      next_cycle();
    end
    pready = 1'b0; pslverr = 1'b0; prdata = 32'hFFFF_0000;
    if (timeout || slverr) begin
      push(1'b0, ERR, 1'b0, 1'b0, '0, 1'b0, '0);
      pend_err = 1'b1;
      next_cycle();
    end else if (!wr) begin
      exp_rdata = rd;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; hsel = 1'b0; haddr = '0; htrans = T_IDLE; hwrite = 1'b0; hsize = 3'd2;
    hburst = 3'b000; hwdata = '0; hready_in = 1'b1; prdata = '0; pready = 1'b0; pslverr = 1'b0;
    #3;
    chk("rst_hreadyout", {31'b0, hreadyout}, 32'd1);
    chk("rst_hresp", {30'b0, hresp}, 32'd0);
    chk("rst_hrdata", hrdata, 32'd0);
    chk("rst_paddr", paddr, 32'd0);
    chk("rst_psel", {31'b0, psel}, 32'd0);
    chk("rst_penable", {31'b0, penable}, 32'd0);
    chk("rst_pwrite", {31'b0, pwrite}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle_cycle(1'b0, T_IDLE, 1'b1);
    idle_cycle(1'b0, T_IDLE, 1'b1);

    xfer(T_NONSEQ, 32'h10, 1'b1, 3'd2, 32'hDEAD_BEEF, 32'h0, 0, 1'b0);
    #1;
    chk("write_done_ready", {31'b0, hreadyout}, 32'd1);
    chk("write_done_okay", {30'b0, hresp}, 32'd0);
    idle_cycle(1'b0, T_IDLE, 1'b1);

    xfer(T_NONSEQ, 32'h14, 1'b0, 3'd2, 32'h0, 32'h1234_5678, 2, 1'b0);
    #1;
    chk("read_done_hrdata", hrdata, 32'h1234_5678);
    chk("read_done_ready", {31'b0, hreadyout}, 32'd1);
    idle_cycle(1'b1, T_BUSY, 1'b1);
    idle_cycle(1'b1, T_IDLE, 1'b1);
    idle_cycle(1'b1, T_NONSEQ, 1'b0);
    idle_cycle(1'b0, T_NONSEQ, 1'b1);

    xfer(T_NONSEQ, 32'h20, 1'b1, 3'd2, 32'h0BAD_F00D, 32'h0, 0, 1'b1);
    #1;
    chk("slverr_err2_resp", {30'b0, hresp}, 32'd1);
    chk("slverr_err2_ready", {31'b0, hreadyout}, 32'd1);
    idle_cycle(1'b0, T_IDLE, 1'b1);

    xfer(T_NONSEQ, 32'h0, 1'b1, 3'd3, 32'h1111_1111, 32'h0, 0, 1'b0);
    xfer(T_NONSEQ, 32'h2, 1'b0, 3'd2, 32'h0, 32'h2222_2222, 0, 1'b0);
    xfer(T_NONSEQ, 32'h2, 1'b0, 3'd1, 32'h0, 32'h0000_ABCD, 1, 1'b0);
    xfer(T_NONSEQ, 32'h3, 1'b1, 3'd0, 32'h0000_00A5, 32'h0, 0, 1'b0);
    idle_cycle(1'b0, T_IDLE, 1'b1);

    hburst = 3'b011;
    xfer(T_NONSEQ, 32'h0, 1'b0, 3'd2, 32'h0, 32'hA000_0000, 0, 1'b0);
    xfer(T_SEQ, 32'h4, 1'b0, 3'd2, 32'h0, 32'hA000_0004, 0, 1'b0);
    xfer(T_SEQ, 32'h8, 1'b0, 3'd2, 32'h0, 32'hA000_0008, 0, 1'b0);
    xfer(T_SEQ, 32'hC, 1'b0, 3'd2, 32'h0, 32'hA000_000C, 0, 1'b0);
    hburst = 3'b000;
    idle_cycle(1'b0, T_IDLE, 1'b1);

    xfer(T_NONSEQ, 32'h30, 1'b1, 3'd2, 32'h5555_AAAA, 32'h0, 10, 1'b0);
    idle_cycle(1'b0, T_IDLE, 1'b1);
    idle_cycle(1'b0, T_IDLE, 1'b1);

    // Reset asserted while the bridge sits in ACCESS, away from any clock edge.
    $display("xfer WR addr=00000044 interrupted by reset during ACCESS");
    hsel = 1'b1; htrans = T_NONSEQ; haddr = 32'h44; hwrite = 1'b1; hsize = 3'd2;
    ready_cycle();
    hsel = 1'b0; htrans = T_IDLE; hwdata = 32'h7777_7777;
    push(1'b0, OKAY, 1'b1, 1'b0, 32'h44, 1'b1, 32'h7777_7777);
    next_cycle();
    pready = 1'b0;
    push(1'b0, OKAY, 1'b1, 1'b1, 32'h44, 1'b1, 32'h7777_7777);
    next_cycle();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_psel", {31'b0, psel}, 32'd0);
    chk("arst_penable", {31'b0, penable}, 32'd0);
    chk("arst_hreadyout", {31'b0, hreadyout}, 32'd1);
    chk("arst_hresp", {30'b0, hresp}, 32'd0);
    chk("arst_paddr", paddr, 32'd0);
    chk("arst_pwrite", {31'b0, pwrite}, 32'd0);
    chk("arst_hrdata", hrdata, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_rdata = '0;
    pend_err  = 1'b0;
    idle_cycle(1'b0, T_IDLE, 1'b1);
    xfer(T_NONSEQ, 32'h48, 1'b0, 3'd2, 32'h0, 32'hCAFE_0048, 0, 1'b0);
    idle_cycle(1'b0, T_IDLE, 1'b1);
    idle_cycle(1'b0, T_IDLE, 1'b1);

    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
